// File: rtl/mm_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply blocks.
package mm_pkg;

    localparam int unsigned N_DEF  = 4;
    localparam int unsigned DW_DEF = 16;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(2 * n);
    endfunction

    function automatic int unsigned row_width(input int unsigned n);
        return $clog2(n);
    endfunction

    localparam int unsigned CNT_W = cnt_width(N_DEF);
    localparam int unsigned ROW_W = row_width(N_DEF);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StEmit
    } drain_state_t;

endpackage

// File: rtl/drain_deskew_buf.sv
// N x N result buffer: skewed per-column capture and a row (or column, when
// DRAIN_TRANSPOSE_EN is defined) read mux.
module drain_deskew_buf
    import mm_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [cnt_width(N)-1:0]   i_cnt,
    input  logic [N*DW-1:0]           i_col,
    input  logic [row_width(N)-1:0]   i_rd_idx,
    output logic [N*DW-1:0]           o_rd_data
);

    localparam int unsigned CW = cnt_width(N);

    logic [DW-1:0] r_buf [N][N];

    // Row r of column j arrives at cnt = r + j.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (i_cnt == CW'(r + c)) begin
                        r_buf[r][c] <= i_col[c*DW +: DW];
                    end
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int c = 0; c < N; c++) begin
`ifdef DRAIN_TRANSPOSE_EN
            o_rd_data[c*DW +: DW] = r_buf[c][i_rd_idx];
`else
            o_rd_data[c*DW +: DW] = r_buf[i_rd_idx][c];
`endif
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures the skewed bottom-row result stream and emits the matrix one beat per
// handshake; DRAIN_TRANSPOSE_EN switches the beats to column-major order.
module systolic_result_drain
    import mm_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    drain_start,
    input  logic [N*DW-1:0]         col_in,
    output logic [N*DW-1:0]         out_data,
    output logic [row_width(N)-1:0] out_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CW = cnt_width(N);
    localparam int unsigned RW = row_width(N);

    drain_state_t    r_state;
    drain_state_t    w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_row;
    logic [N*DW-1:0] w_rd_data;
    logic            w_accept;
    logic            w_last_cap;
    logic            w_last_row;
    logic            w_we;

    assign w_accept   = (r_state == StEmit) && out_ready && enable;
    assign w_last_cap = (r_cnt == CW'(2 * N - 2));
    assign w_last_row = (r_row == RW'(N - 1));
    assign w_we       = (r_state == StCapture) && enable;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
        end else if (enable) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (drain_start) w_state_next = StCapture;
            end
            StCapture: begin
                if (w_last_cap) w_state_next = StEmit;
            end
            StEmit: begin
                // A start on the final accept chains straight into the next capture.
                if (w_accept && w_last_row) begin
                    w_state_next = drain_start ? StCapture : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        out_valid = (r_state == StEmit);
        out_row   = out_valid ? r_row : '0;
        out_data  = out_valid ? w_rd_data : '0;
        busy      = (r_state != StIdle);
        done      = w_accept && w_last_row;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_row <= '0;
        end else if (enable) begin
            r_cnt <= (r_state == StCapture) ? r_cnt + 1'b1 : '0;
            if (r_state != StEmit) begin
                r_row <= '0;
            end else if (w_accept) begin
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end
        end
    end

    drain_deskew_buf #(
        .N  (N),
        .DW (DW)
    ) u_buf (
        .clk       (clk),
        .i_we      (w_we),
        .i_cnt     (r_cnt),
        .i_col     (col_in),
        .i_rd_idx  (r_row),
        .o_rd_data (w_rd_data)
    );

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: reset/idle vector table, directed drains and
// randomized drains checked against a cycle-level timeline model.
module tb_systolic_result_drain;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned W  = N * DW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic                 drain_start = 1'b0;
    logic                 out_ready = 1'b0;
    logic [W-1:0]         col_in = '0;
    logic [W-1:0]         out_data;
    logic [$clog2(N)-1:0] out_row;
    logic                 out_valid;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mat [N][N];

    always #5 clk = ~clk;

    systolic_result_drain #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .drain_start (drain_start),
        .col_in      (col_in),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Beat k of the result: row k, or column k in the transposing build.
    function automatic logic [W-1:0] beat(input int k);
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) begin
`ifdef DRAIN_TRANSPOSE_EN
            v[c*DW +: DW] = mat[c][k];
`else
            v[c*DW +: DW] = mat[k][c];
`endif
        end
        return v;
    endfunction

    task automatic fill_rand();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mat[r][c] = DW'($urandom);
    endtask

    // mode 0: free flow, 1: ready low 3 cycles on beat 1, 2: random ready/enable,
    // 3: enable low 2 cycles at capture step 3.
    task automatic drain(input int mode, input bit skip_start, input bit poke_mid,
                         input bit chain, input bit rst_mid);
        int act = 0;
        int acc = 0;
        int stall = 0;
        int cyc = 1;
        int first_seen = -1;
        bit en, rdy, exp_v, last;
        if (!skip_start) begin
            drain_start = 1'b1;
            enable = 1'b1;
            out_ready = 1'b1;
            col_in = {$urandom, $urandom};
            #2;
            chk("start_busy", busy, 0);
            chk("start_valid", out_valid, 0);
            @(posedge clk);
            #1;
        end
        while (acc < N) begin
            if (cyc > 300) begin
                checks++;
                errors++;
                $display("FAIL timeout: got %0d beats want %0d", acc, N);
                break;
            end
            exp_v = (act >= 2 * N - 1);
            en = 1'b1;
            rdy = 1'b1;
            case (mode)
                1: if (exp_v && acc == 1 && stall < 3) begin rdy = 1'b0; stall++; end
                2: begin en = ($urandom_range(0, 3) != 0); rdy = 1'($urandom_range(0, 1)); end
                3: if (act == 3 && stall < 2) begin en = 1'b0; stall++; end
                default: ;
            endcase
            enable = en;
            out_ready = rdy;
            last = exp_v && rdy && en && (acc == N - 1);
            drain_start = (poke_mid && exp_v && acc == 1) || (chain && last);
            for (int j = 0; j < N; j++) begin
                int t;
                t = act - j;
                col_in[j*DW +: DW] = (en && !exp_v && t >= 0 && t < N) ? mat[t][j]
                                                                       : DW'($urandom);
            end
            if (rst_mid && exp_v && acc == 2) reset = 1'b0;
            #2;
            chk("busy", busy, 1);
            chk("valid", out_valid, exp_v);
            chk("done", done, last);
            if (exp_v) begin
                chk("row", out_row, acc);
                chk("data", out_data, beat(acc));
            end
            if (out_valid && first_seen < 0) first_seen = cyc;
            @(posedge clk);
            #1;
            if (!reset) begin
                reset = 1'b1;
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                return;
            end
            if (en) begin
                if (exp_v && rdy) acc++;
                act++;
            end
            cyc++;
        end
        drain_start = 1'b0;
        if (mode == 0) chk("latency", first_seen, 2 * N);
        if (!chain) begin
            #2;
            chk("post_busy", busy, 0);
            chk("post_valid", out_valid, 0);
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic rst_n;
        logic en;
        logic start;
        logic exp_busy;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};  // start ignored while disabled
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0};  // reset wins over enable=0
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0};

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reset = vecs[i].rst_n;
            enable = vecs[i].en;
            drain_start = vecs[i].start;
            col_in = {$urandom, $urandom};
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_valid", i), out_valid, 0);
            chk($sformatf("vec%0d_done", i), done, 0);
            chk($sformatf("vec%0d_data", i), out_data, 0);
            chk($sformatf("vec%0d_row", i), out_row, 0);
        end
        drain_start = 1'b0;
        reset = 1'b1;

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mat[r][c] = DW'(10 * r + c);
        drain(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain(1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain(3, 1'b0, 1'b0, 1'b0, 1'b0);

        drain(0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mat[r][c] = DW'(100 + r);
        drain(0, 1'b1, 1'b0, 1'b0, 1'b0);

        fill_rand();
        drain(0, 1'b0, 1'b0, 1'b0, 1'b1);
        fill_rand();
        drain(0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            fill_rand();
            drain(2, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
